// File: rtl/mips_multicycle_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : mips_multicycle_ctrl_if
// Brief    : Control-unit <-> datapath bundle: instruction fields, zero flag,
//            and every mux select / write enable of the multicycle datapath.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       pcen;

    modport master (
        input  op, funct, zero,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, pcen
    );

    modport slave (
        output op, funct, zero,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, pcen
    );
endinterface

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
//------------------------------------------------------------------------------
// Module   : mips_multicycle_ctrl
// Brief    : Moore sequencer and ALU decoder for the multicycle MIPS datapath.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mips_multicycle_ctrl (
    input  wire logic             clk,
    input  wire logic             reset,
    mips_multicycle_ctrl_if.master io_dp
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       pcwrite;
        logic       branch;
    } ctl_t;

    // Moore control word for a state; anything not listed stays at zero.
    function automatic ctl_t ctl_of(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH:   begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
            S_DECODE:  c.alusrcb = 2'b11;
            S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_MEMRD:   c.iord = 1'b1;
            S_MEMWB:   begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
            S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
            S_RTYPEEX: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            S_RTYPEWB: begin c.regwrite = 1'b1; c.regdst = 1'b1; end
            S_BEQEX:   begin
                c.alusrca = 1'b1; c.aluop = 2'b01; c.branch = 1'b1; c.pcsrc = 2'b01;
            end
            S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_ADDIWB:  c.regwrite = 1'b1;
            S_JEX:     begin c.pcwrite = 1'b1; c.pcsrc = 2'b10; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    state_t     r_state;
    state_t     w_next;
    ctl_t       r_ctl;
    logic [2:0] w_alucontrol;

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (io_dp.op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_RTYPE:       w_next = S_RTYPEEX;
                    c_OP_BEQ:         w_next = S_BEQEX;
                    c_OP_ADDI:        w_next = S_ADDIEX;
                    c_OP_J:           w_next = S_JEX;
                    default:          w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (io_dp.op == c_OP_LW)
                    w_next = S_MEMRD;
                else if (io_dp.op == c_OP_SW)
                    w_next = S_MEMWR;
                else
                    w_next = S_FETCH;
            end
            S_MEMRD:   w_next = S_MEMWB;
            S_RTYPEEX: w_next = S_RTYPEWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    // The control word is registered alongside the state so outputs leave flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ctl   <= ctl_of(S_FETCH);
        end else begin
            r_state <= w_next;
            r_ctl   <= ctl_of(w_next);
        end
    end

    always_comb begin
        w_alucontrol = 3'b010;
        case (r_ctl.aluop)
            2'b01: w_alucontrol = 3'b110;
            2'b10: begin
                case (io_dp.funct)
                    c_FN_ADD: w_alucontrol = 3'b010;
                    c_FN_SUB: w_alucontrol = 3'b110;
                    c_FN_AND: w_alucontrol = 3'b000;
                    c_FN_OR:  w_alucontrol = 3'b001;
                    c_FN_SLT: w_alucontrol = 3'b111;
                    default:  w_alucontrol = 3'b010;
                endcase
            end
            default: w_alucontrol = 3'b010;
        endcase
    end

    // Architectural write enables are killed while reset is high.
    assign io_dp.iord       = r_ctl.iord;
    assign io_dp.memwrite   = r_ctl.memwrite & ~reset;
    assign io_dp.irwrite    = r_ctl.irwrite  & ~reset;
    assign io_dp.regdst     = r_ctl.regdst;
    assign io_dp.memtoreg   = r_ctl.memtoreg;
    assign io_dp.regwrite   = r_ctl.regwrite & ~reset;
    assign io_dp.alusrca    = r_ctl.alusrca;
    assign io_dp.alusrcb    = r_ctl.alusrcb;
    assign io_dp.pcsrc      = r_ctl.pcsrc;
    assign io_dp.alucontrol = w_alucontrol;
    assign io_dp.pcen       = (r_ctl.pcwrite | (r_ctl.branch & io_dp.zero)) & ~reset;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_mips_multicycle_ctrl
// Brief    : Scoreboard bench for the multicycle MIPS control unit.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mips_multicycle_ctrl;

    localparam int PH_F = 0, PH_D = 1, PH_MA = 2, PH_MR = 3, PH_MWB = 4, PH_MWR = 5;
    localparam int PH_RE = 6, PH_RW = 7, PH_BE = 8, PH_AE = 9, PH_AW = 10, PH_JE = 11;

    typedef struct {
        logic [14:0] vec;
        int          ph;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .io_dp (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected output vector for one cycle in a given instruction step.
    function automatic logic [14:0] model(input int ph, input logic [5:0] f,
                                          input logic z, input logic rst);
        logic iord, mw, irw, rd, m2r, rw, asa, pcw, br;
        logic [1:0] asb, pcs;
        logic [2:0] alu;
        iord = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; asa = 0; pcw = 0; br = 0;
        asb = 2'b00; pcs = 2'b00; alu = 3'b010;
        case (ph)
            PH_F:   begin irw = 1; pcw = 1; asb = 2'b01; end
            PH_D:   asb = 2'b11;
            PH_MA:  begin asa = 1; asb = 2'b10; end
            PH_MR:  iord = 1;
            PH_MWB: begin rw = 1; m2r = 1; end
            PH_MWR: begin iord = 1; mw = 1; end
            PH_RE:  begin asa = 1; alu = alu_of_funct(f); end
            PH_RW:  begin rw = 1; rd = 1; end
            PH_BE:  begin asa = 1; alu = 3'b110; br = 1; pcs = 2'b01; end
            PH_AE:  begin asa = 1; asb = 2'b10; end
            PH_AW:  rw = 1;
            PH_JE:  begin pcw = 1; pcs = 2'b10; end
            default: ;
        endcase
        if (rst) begin
            mw = 0; irw = 0; rw = 0; pcw = 0; br = 0;
        end
        return {iord, mw, irw, rd, m2r, rw, asa, asb, pcs, alu, pcw | (br & z)};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
                bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol,
                bus.pcen};
    endfunction

    // Drive one clock cycle of stimulus and enqueue what the DUT must show in it.
    task automatic step(input int ph, input logic rst, input logic [5:0] o,
                        input logic [5:0] f);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        bus.op    = o;
        bus.funct = f;
        bus.zero  = 1'($urandom_range(0, 1));
        cyc++;
        e.vec = model(ph, f, bus.zero, rst);
        e.ph  = ph;
        e.cyc = cyc;
        sb_q.push_back(e);
    endtask

    // Instruction sequence per opcode, from the instruction-class rules.
    task automatic issue(input logic [5:0] o, input logic [5:0] f);
        int seq[$];
        seq = '{PH_F, PH_D};
        case (o)
            6'b100011: seq = {seq, PH_MA, PH_MR, PH_MWB};
            6'b101011: seq = {seq, PH_MA, PH_MWR};
            6'b000000: seq = {seq, PH_RE, PH_RW};
            6'b001000: seq = {seq, PH_AE, PH_AW};
            6'b000100: seq.push_back(PH_BE);
            6'b000010: seq.push_back(PH_JE);
            default: ;
        endcase
        foreach (seq[i]) step(seq[i], 1'b0, o, f);
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [14:0] got;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = dut_vec();
            n_cmp++;
            if (got !== e.vec) begin
                n_bad++;
                $display("FAIL ctl cyc=%0d step=%0d op=%b funct=%b zero=%b rst=%b got=%b want=%b",
                         e.cyc, e.ph, bus.op, bus.funct, bus.zero, reset, got, e.vec);
            end
        end
    end

    initial begin
        logic [5:0] legal_ops [6];
        logic [5:0] fns [6];
        logic [5:0] o, f;
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        fns       = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
        bus.op = 6'b0; bus.funct = 6'b0; bus.zero = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Reset-state checks while reset is still high.
        step(PH_F, 1'b1, 6'b0, 6'b0);
        step(PH_F, 1'b1, 6'b0, 6'b0);

        // lw aborted by reset held three cycles from MEMRD.
        step(PH_F,  1'b0, 6'b100011, 6'b0);
        step(PH_D,  1'b0, 6'b100011, 6'b0);
        step(PH_MA, 1'b0, 6'b100011, 6'b0);
        step(PH_MR, 1'b1, 6'b100011, 6'b0);
        step(PH_F,  1'b1, 6'b100011, 6'b0);
        step(PH_F,  1'b1, 6'b100011, 6'b0);

        issue(6'b100011, 6'b0);
        foreach (fns[i]) issue(6'b000000, fns[i]);
        issue(6'b000100, 6'b0);
        issue(6'b000100, 6'b0);
        issue(6'b101011, 6'b0);
        issue(6'b000010, 6'b0);
        issue(6'b111111, 6'b0);
        issue(6'b001000, 6'b0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) >= 6) o = 6'($urandom());
            else                           o = legal_ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) f = 6'($urandom());
            else                           f = fns[$urandom_range(0, 5)];
            issue(o, f);
            if ($urandom_range(0, 40) == 0) begin
                step(PH_F, 1'b1, o, f);
                step(PH_F, 1'b1, o, f);
            end
        end

        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Control unit for the multicycle 32-bit MIPS core. A Moore state machine sequences the shared datapath (PC, unified instruction/data memory, instruction register, register file, ALU) over 3–5 cycles per instruction. It also decodes opcode/funct into the 3-bit ALU operation select, so the single ALU serves PC increment, address generation, branch compare and execute. It sits beside the datapath and drives every mux select and write enable in it.

## Interface
- No parameters; opcode and funct encodings are fixed constants inside the block.
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- op  in  6  instruction[31:26] from instruction register
- funct  in  6  instruction[5:0] from instruction register
- zero  in  1  ALU zero flag (combinational, same cycle)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  data memory write enable
- irwrite  out  1  instruction register load enable
- regdst  out  1  destination register: 0 = rt, 1 = rd
- memtoreg  out  1  write-back data: 0 = ALUOut, 1 = memory data register
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- pcsrc  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target {PC[31:28], instr[25:0], 2'b00}
- alucontrol  out  3  ALU operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- pcen  out  1  PC load enable = pcwrite | (branch & zero)

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Funct, R-type only: 100000 add→010, 100010 sub→110, 100100 and→000, 100101 or→001, 101010 slt→111. Any other funct→010.
- Internal aluop (2 bits): 00 = add, 01 = sub, 10 = use funct. Drives alucontrol combinationally.
- States and non-default outputs. Defaults: all enables 0, all selects 0, aluop 00.
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, pcsrc=00 → DECODE.
  - DECODE: alusrcb=11 (precompute branch target into ALUOut). Next state by op: lw/sw→MEMADR, R-type→RTYPEEX, beq→BEQEX, addi→ADDIEX, j→JEX; any other op→FETCH (treated as NOP).
  - MEMADR: alusrca=1, alusrcb=10 → MEMRD if op=lw, MEMWR if op=sw.
  - MEMRD: iord=1 → MEMWB.
  - MEMWB: regwrite=1, memtoreg=1, regdst=0 → FETCH.
  - MEMWR: iord=1, memwrite=1 → FETCH.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10 → RTYPEWB.
  - RTYPEWB: regwrite=1, regdst=1, memtoreg=0 → FETCH.
  - BEQEX: alusrca=1, alusrcb=00, aluop=01, branch=1, pcsrc=01 → FETCH.
  - ADDIEX: alusrca=1, alusrcb=10 → ADDIWB.
  - ADDIWB: regwrite=1, regdst=0, memtoreg=0 → FETCH.
  - JEX: pcwrite=1, pcsrc=10 → FETCH.
- Unreachable state encodings recover to FETCH on the next edge.

## Timing
- Reset: on any rising edge with reset=1, state←FETCH, regardless of current state (mid-instruction abort allowed; no partial write completes after the edge). While reset=1, memwrite, regwrite, irwrite and pcen are forced to 0 combinationally.
- First cycle after reset deasserts is FETCH.
- All outputs are combinational from state, op and funct. zero enters only pcen, and only in BEQEX.
- CPI: lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; unknown op 2.
- op/funct must stay stable from DECODE to the end of the instruction. irwrite is asserted only in FETCH.
- beq: pcen = zero in BEQEX; not taken leaves PC = PC+4 written in FETCH.

## Test plan
- Reset held 3 cycles during MEMRD, then released → pcen/memwrite/regwrite/irwrite = 0 throughout; next cycle FETCH: irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- lw (op 100011) → 5 cycles; MEMADR alusrcb=10; MEMRD iord=1; MEMWB regwrite=1, memtoreg=1; then FETCH.
- R-type funct 101010 → RTYPEEX alucontrol=111; RTYPEWB regwrite=1, regdst=1. Repeat for 100010→110, 100100→000, 100101→001, 111111→010.
- beq with zero=1 → BEQEX pcen=1, pcsrc=01, alucontrol=110. With zero=0 → pcen=0. Both take 3 cycles.
- sw then j → sw: MEMWR memwrite=1, iord=1, no regwrite. j: JEX pcen=1, pcsrc=10. Total 7 cycles.
- Illegal op 111111 → FETCH, DECODE, FETCH with no memwrite/regwrite asserted.
